// File: rtl/mi_nios_cpu_jtag_monitor_access.sv
// Purpose : runs single-word debug-memory reads/writes commanded by the JTAG debug-module wrapper.
// Latency : strobe in cycle N -> request from N+1 -> monitor_ready high two cycles after the strobe when waitrequest is low.
// Backpr. : request, address and data are held while mem_waitrequest=1; strobes arriving while busy are dropped and flag an error.
//
// Ports:
//   clk, reset                         system clock, synchronous active-high reset
//   jdo[37:0]                          command/data word: [ADDR_W+16:17] address, [35] clear error,
//                                      [34] read-after-load, [34:3] write data
//   take_action_ocimem_a               address load (optionally followed by a read)
//   take_action_ocimem_b               write MonDReg at MonAReg
//   take_no_action_ocimem_a            read at MonAReg
//   mem_addr/mem_wdata/mem_read/mem_write/mem_rdata/mem_waitrequest   debug memory master
//   MonDReg, monitor_ready, monitor_error                            status scanned back out
//
// Optional build macro MONITOR_TIMEOUT_EN: aborts an access that stalls for TIMEOUT_CYC cycles.
module mi_nios_cpu_jtag_monitor_access #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic any_strobe;
    logic multi_strobe;

    assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b)
                        | (take_action_ocimem_a & take_no_action_ocimem_a)
                        | (take_action_ocimem_b & take_no_action_ocimem_a);

    // Jdo bits that carry no meaning for this stage.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

`ifdef MONITOR_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    always_comb begin
        state_d = state_q;
        mon_a_d = mon_a_q;
        mon_d_d = mon_d_q;
        wdata_d = wdata_q;
        err_d   = err_q;
`ifdef MONITOR_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MONITOR_TIMEOUT_EN
                // Counter is zero on the first request cycle of every access.
                cnt_d = '0;
`endif
                if (take_action_ocimem_a) begin
                    mon_a_d = jdo[ADDR_W+16:17];
                    if (jdo[35]) begin
                        err_d = 1'b0;
                    end
                    if (jdo[34]) begin
                        state_d = RD;
                    end
                end else if (take_action_ocimem_b) begin
                    mon_d_d = jdo[34:3];
                    wdata_d = jdo[34:3];
                    state_d = WR;
                end else if (take_no_action_ocimem_a) begin
                    state_d = RD;
                end
                // Evaluated after the clear so a collision always leaves the flag set.
                if (multi_strobe) begin
                    err_d = 1'b1;
                end
            end
            RD, WR: begin
                if (any_strobe) begin
                    err_d = 1'b1;
                end
                if (!mem_waitrequest) begin
                    if (state_q == RD) begin
                        mon_d_d = mem_rdata;
                    end
                    mon_a_d = mon_a_q + 1'b1;
                    state_d = IDLE;
                end
`ifdef MONITOR_TIMEOUT_EN
                else if (cnt_q >= CNT_LAST) begin
                    // Abort: registers keep their pre-access values.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mon_a_q <= '0;
            mon_d_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MONITOR_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef MONITOR_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // MonAReg only moves on completion, so it is the access address for the whole request.
    assign mem_addr      = mon_a_q;
    assign mem_wdata     = wdata_q;
    assign mem_read      = (state_q == RD);
    assign mem_write     = (state_q == WR);
    assign MonDReg       = mon_d_q;
    assign monitor_ready = (state_q == IDLE);
    assign monitor_error = err_q;

endmodule

// File: tb/tb_mi_nios_cpu_jtag_monitor_access.sv
module tb_mi_nios_cpu_jtag_monitor_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata;
    logic        mem_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mi_nios_cpu_jtag_monitor_access #(.ADDR_W(10), .TIMEOUT_CYC(4)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_rdata               (mem_rdata),
        .mem_waitrequest         (mem_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    function automatic logic [37:0] jdo_a(input logic [9:0] addr, input logic rd, input logic clr);
        logic [37:0] v;
        v = '0;
        v[26:17] = addr;
        v[34] = rd;
        v[35] = clr;
        return v;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; jdo = '0; clear_strobes(); mem_rdata = '0; mem_waitrequest = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", monitor_ready); end
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rst_req got rd=%b wr=%b exp 0 0", mem_read, mem_write); end
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL rst_mondreg got %h exp 0", MonDReg); end
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL rst_error got %b exp 0", monitor_error); end
        checks++; if (mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_addr_wdata got %h %h exp 0 0", mem_addr, mem_wdata); end
    endtask

    task automatic test_addr_read();
        take_action_ocimem_a = 1'b1; jdo = jdo_a(10'h005, 1'b1, 1'b0);
        mem_waitrequest = 1'b0; mem_rdata = 32'hDEADBEEF;
        tick(); clear_strobes();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 10'h005) begin errors++; $display("FAIL ld_rd_req got rd=%b addr=%h exp 1 005", mem_read, mem_addr); end
        checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL ld_rd_busy got %b exp 0", monitor_ready); end
        tick();
        checks++; if (mem_read !== 1'b0 || monitor_ready !== 1'b1) begin errors++; $display("FAIL ld_rd_done got rd=%b rdy=%b exp 0 1", mem_read, monitor_ready); end
        checks++; if (MonDReg !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_rd_data got %h exp deadbeef", MonDReg); end
    endtask

    task automatic test_write_stall();
        take_action_ocimem_b = 1'b1; jdo = jdo_b(32'h12345678); mem_waitrequest = 1'b1;
        tick(); clear_strobes();
        for (int i = 0; i < 4; i++) begin
            mem_waitrequest = (i < 3);
            checks++;
            if (mem_write !== 1'b1 || mem_addr !== 10'h006 || mem_wdata !== 32'h12345678 || monitor_ready !== 1'b0) begin
                errors++; $display("FAIL wr_hold[%0d] got wr=%b addr=%h wd=%h rdy=%b exp 1 006 12345678 0", i, mem_write, mem_addr, mem_wdata, monitor_ready);
            end
            tick();
        end
        checks++; if (mem_write !== 1'b0 || monitor_ready !== 1'b1) begin errors++; $display("FAIL wr_done got wr=%b rdy=%b exp 0 1", mem_write, monitor_ready); end
        checks++; if (MonDReg !== 32'h12345678) begin errors++; $display("FAIL wr_mondreg got %h exp 12345678", MonDReg); end
        // MonAReg advanced to 7: observed via the next read address.
        take_no_action_ocimem_a = 1'b1; mem_rdata = 32'h00000777;
        tick(); clear_strobes();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 10'h007) begin errors++; $display("FAIL wr_incr got rd=%b addr=%h exp 1 007", mem_read, mem_addr); end
        tick();
    endtask

    task automatic test_wrap();
        take_action_ocimem_a = 1'b1; jdo = jdo_a(10'h3FF, 1'b0, 1'b0);
        tick(); clear_strobes();
        checks++; if (mem_read !== 1'b0 || monitor_ready !== 1'b1) begin errors++; $display("FAIL ld_only got rd=%b rdy=%b exp 0 1", mem_read, monitor_ready); end
        take_no_action_ocimem_a = 1'b1; mem_rdata = 32'hCAFEF00D; mem_waitrequest = 1'b0;
        tick(); clear_strobes();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 10'h3FF) begin errors++; $display("FAIL wrap_rd got rd=%b addr=%h exp 1 3ff", mem_read, mem_addr); end
        tick();
        checks++; if (MonDReg !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_data got %h exp cafef00d", MonDReg); end
        take_no_action_ocimem_a = 1'b1;
        tick(); clear_strobes();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 10'h000) begin errors++; $display("FAIL wrap_addr got rd=%b addr=%h exp 1 000", mem_read, mem_addr); end
        tick();
    endtask

    task automatic test_busy_collision();
        take_action_ocimem_a = 1'b1; jdo = jdo_a(10'h010, 1'b0, 1'b0);
        tick(); clear_strobes();
        take_action_ocimem_b = 1'b1; jdo = jdo_b(32'hA5A5A5A5); mem_waitrequest = 1'b1;
        tick(); clear_strobes();
        take_no_action_ocimem_a = 1'b1;
        tick(); clear_strobes();
        checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL busy_err got %b exp 1", monitor_error); end
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 10'h010) begin errors++; $display("FAIL busy_inflight got wr=%b rd=%b addr=%h exp 1 0 010", mem_write, mem_read, mem_addr); end
        mem_waitrequest = 1'b0;
        tick();
        checks++; if (mem_write !== 1'b0 || monitor_ready !== 1'b1 || MonDReg !== 32'hA5A5A5A5) begin errors++; $display("FAIL busy_done got wr=%b rdy=%b d=%h exp 0 1 a5a5a5a5", mem_write, monitor_ready, MonDReg); end
        tick();
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL busy_no_extra_rd got %b exp 0", mem_read); end
        take_action_ocimem_a = 1'b1; jdo = jdo_a(10'h000, 1'b0, 1'b1);
        tick(); clear_strobes();
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", monitor_error); end
    endtask

    task automatic test_simultaneous();
        take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1; jdo = jdo_a(10'h020, 1'b0, 1'b0);
        tick(); clear_strobes();
        checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || monitor_ready !== 1'b1) begin errors++; $display("FAIL simul_req got wr=%b rd=%b rdy=%b exp 0 0 1", mem_write, mem_read, monitor_ready); end
        checks++; if (monitor_error !== 1'b1 || MonDReg !== 32'hA5A5A5A5) begin errors++; $display("FAIL simul_err got err=%b d=%h exp 1 a5a5a5a5", monitor_error, MonDReg); end
        take_no_action_ocimem_a = 1'b1; mem_rdata = 32'h11112222;
        tick(); clear_strobes();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 10'h020) begin errors++; $display("FAIL simul_addr got rd=%b addr=%h exp 1 020", mem_read, mem_addr); end
        tick();
        take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1; jdo = jdo_a(10'h000, 1'b0, 1'b1);
        tick(); clear_strobes();
        checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL clr_vs_set got %b exp 1", monitor_error); end
        take_action_ocimem_a = 1'b1; jdo = jdo_a(10'h000, 1'b0, 1'b1);
        tick(); clear_strobes();
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL clr_alone got %b exp 0", monitor_error); end
    endtask

    task automatic test_reset_mid_read();
        take_action_ocimem_a = 1'b1; jdo = jdo_a(10'h0AA, 1'b1, 1'b0); mem_waitrequest = 1'b1; mem_rdata = 32'h99999999;
        tick(); clear_strobes();
        take_action_ocimem_b = 1'b1;
        tick(); clear_strobes();
        checks++; if (mem_read !== 1'b1 || monitor_error !== 1'b1) begin errors++; $display("FAIL pre_rst got rd=%b err=%b exp 1 1", mem_read, monitor_error); end
        reset = 1'b1; mem_waitrequest = 1'b0;
        tick(); reset = 1'b0;
        checks++; if (mem_read !== 1'b0 || monitor_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_req got rd=%b rdy=%b exp 0 1", mem_read, monitor_ready); end
        checks++; if (MonDReg !== 32'h0 || monitor_error !== 1'b0 || mem_addr !== 10'h000) begin errors++; $display("FAIL mid_rst_regs got d=%h err=%b addr=%h exp 0 0 000", MonDReg, monitor_error, mem_addr); end
    endtask

`ifdef MONITOR_TIMEOUT_EN
    task automatic test_timeout();
        take_action_ocimem_a = 1'b1; jdo = jdo_a(10'h055, 1'b1, 1'b0); mem_waitrequest = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick(); clear_strobes();
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_read !== 1'b1 || mem_addr !== 10'h055) begin errors++; $display("FAIL to_hold[%0d] got rd=%b addr=%h exp 1 055", i, mem_read, mem_addr); end
            tick();
        end
        checks++; if (mem_read !== 1'b0 || monitor_ready !== 1'b1 || monitor_error !== 1'b1) begin errors++; $display("FAIL to_abort got rd=%b rdy=%b err=%b exp 0 1 1", mem_read, monitor_ready, monitor_error); end
        checks++; if (MonDReg !== 32'h0 || mem_addr !== 10'h055) begin errors++; $display("FAIL to_regs got d=%h addr=%h exp 0 055", MonDReg, mem_addr); end
        mem_waitrequest = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_addr_read();
        test_write_stall();
        test_wrap();
        test_busy_collision();
        test_simultaneous();
        test_reset_mid_read();
`ifdef MONITOR_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
